pc_fetch_ctrl: RTL and testbench

//   Parametrised program-counter and fetch controller; successor to the single-cycle PC register.

---
 rtl/pc_fetch_ctrl.sv | 73 +++++++
 tb/tb_pc_fetch_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch controller over an imem req/ack handshake,
// with held branch redirects and a parking misaligned-fetch exception.
module pc_fetch_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(32'h8000_0000),
    parameter int                INSN_BYTES = 4,
    parameter int                STALL_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_addr_i,
    input  logic               branch_en_i,
    input  logic [ADDR_W-1:0]  branch_addr_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  fetch_pc_o,
    output logic               fetch_valid_o,
    output logic [31:0]        exc_type_o,
    output logic               pause_req_o
);
    typedef enum logic [1:0] {BOOT, FETCH, ERR} state_t;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSN_BYTES - 1);
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INSN_BYTES);
    state_t            state, state_nx;
    logic              pend, misaligned, advance, unused_stall;
    logic [ADDR_W-1:0] pend_addr, next_pc;
    // Mask is zero for single-byte instructions, so misaligned is constant 0 there.
    assign misaligned   = |(pc_o & ALIGN_MASK);
    assign imem_req_o   = state == FETCH && !misaligned && !stall_i[0] && !flush_i;
    assign imem_addr_o  = pc_o;
    assign advance      = imem_req_o && imem_ack_i;
    assign next_pc      = branch_en_i ? branch_addr_i : pend ? pend_addr : pc_o + INC;
    assign exc_type_o   = {misaligned, 31'b0};
    assign pause_req_o  = misaligned;
    assign unused_stall = ^stall_i;
    always_comb begin
        state_nx = state;
        state_nx = flush_i ? FETCH :
                   state == BOOT ? FETCH :
                   (state == FETCH && misaligned) ? ERR : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_nx;
    end
    // A redirect seen while no fetch completes is parked until the next advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o          <= RESET_VEC;
            fetch_pc_o    <= '0;
            fetch_valid_o <= 1'b0;
            pend          <= 1'b0;
            pend_addr     <= '0;
        end else begin
            fetch_valid_o <= advance;
            if (flush_i) begin
                pc_o <= flush_addr_i;
                pend <= 1'b0;
            end else if (advance) begin
                pc_o       <= next_pc;
                fetch_pc_o <= pc_o;
                pend       <= 1'b0;
            end else if (branch_en_i && state != ERR) begin
                pend      <= 1'b1;
                pend_addr <= branch_addr_i;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed + random stimulus against a behavioural fetch model,
// with a per-cycle scoreboard and a queue of expected fetched PCs.
module tb_pc_fetch_ctrl;
    localparam logic [31:0] RV = 32'h8000_0000;
    logic        clk = 0, rst = 0, flush = 0, br = 0, ack = 0;
    logic [5:0]  stall = 0;
    logic [31:0] faddr = 0, baddr = 0;
    logic        req, fv, pause, req2, fv2, pause2;
    logic [31:0] iaddr, pc, fpc, exc, iaddr2, pc2, fpc2, exc2;
    int checks = 0, passes = 0;

    pc_fetch_ctrl u1 (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .flush_addr_i(faddr),
        .branch_en_i(br), .branch_addr_i(baddr), .imem_req_o(req), .imem_addr_o(iaddr),
        .imem_ack_i(ack), .pc_o(pc), .fetch_pc_o(fpc), .fetch_valid_o(fv),
        .exc_type_o(exc), .pause_req_o(pause));
    pc_fetch_ctrl #(.INSN_BYTES(2)) u2 (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .flush_addr_i(faddr),
        .branch_en_i(br), .branch_addr_i(baddr), .imem_req_o(req2), .imem_addr_o(iaddr2),
        .imem_ack_i(ack), .pc_o(pc2), .fetch_pc_o(fpc2), .fetch_valid_o(fv2),
        .exc_type_o(exc2), .pause_req_o(pause2));

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          req;
        bit          mis;
        bit          fv;
    } snap_t;
    snap_t       snapq[$];
    logic [31:0] fq[$];

    // Reference model: mode 0 = boot, 1 = fetching, 2 = parked on exception.
    int          mode = 0;
    bit          mvalid = 0, mpend = 0, mfv = 0;
    logic [31:0] mpc = 0, mpaddr = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step(bit r, bit st, bit fl, logic [31:0] fa, bit b, logic [31:0] ba, bit ak);
        snap_t s;
        bit    mis, mreq;
        @(negedge clk);
        rst   = r;
        stall = {5'($urandom), st};
        flush = fl;
        faddr = fa;
        br    = b;
        baddr = ba;
        ack   = ak;
        mis   = (mpc % 4) != 0;
        mreq  = mvalid && mode == 1 && !mis && !st && !fl;
        s.v = mvalid; s.pc = mpc; s.req = mreq; s.mis = mis; s.fv = mfv;
        snapq.push_back(s);
        if (r) begin
            mvalid = 1; mode = 0; mpc = RV; mpend = 0; mfv = 0;
        end else if (mvalid) begin
            if (fl) begin
                mpc = fa; mpend = 0; mfv = 0; mode = 1;
            end else begin
                mfv = mreq && ak;
                if (mfv) begin
                    fq.push_back(mpc);
                    mpc   = b ? ba : mpend ? mpaddr : mpc + 4;
                    mpend = 0;
                end else if (b && mode != 2) begin
                    mpend = 1; mpaddr = ba;
                end
                if (mode == 0) mode = 1;
                else if (mode == 1 && mis) mode = 2;
            end
        end
    endtask

    always @(negedge clk) begin
        snap_t       s;
        logic [31:0] e;
        #2;
        if (snapq.size() > 0) begin
            s = snapq.pop_front();
            if (s.v) begin
                chk("pc", pc, s.pc);
                chk("imem_addr", iaddr, s.pc);
                chk("imem_req", 32'(req), 32'(s.req));
                chk("exc_type", exc, {s.mis, 31'b0});
                chk("pause_req", 32'(pause), 32'(s.mis));
                chk("fetch_valid", 32'(fv), 32'(s.fv));
                if (s.fv) begin
                    e = fq.pop_front();
                    chk("fetch_pc", fpc, e);
                end
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'h8000_0002, 1);
        step(0, 0, 0, 0, 1, 32'h8000_0300, 1);
        #2;
        chk("u2_pc_half_aligned", pc2, 32'h8000_0002);
        chk("u2_exc", exc2, 32'h0);
        chk("u2_req", 32'(req2), 32'h1);
        step(0, 0, 0, 0, 1, 32'h8000_0400, 1);
        step(0, 0, 0, 0, 1, 32'h8000_0500, 1);
        step(0, 0, 1, 32'h8000_0180, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 32'h8000_0100, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h8000_0180, 1, 32'h8000_0200, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1, 32'h8000_0040, 1);
        repeat (3) step(0, 1, 0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            bit          r, st, fl, b, ak;
            logic [31:0] fa, ba;
            r  = $urandom_range(0, 99) < 1;
            st = $urandom_range(0, 99) < 15;
            fl = $urandom_range(0, 99) < 4;
            b  = $urandom_range(0, 99) < 12;
            ak = $urandom_range(0, 99) < 70;
            fa = $urandom & 32'hFFFF_FFFC;
            ba = $urandom;
            if ($urandom_range(0, 7) != 0) ba = ba & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) ba = 32'hFFFF_FFF8;
            step(r, st, fl, fa, b, ba, ak);
        end
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #3;
        chk("fetch_queue_drained", 32'(fq.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
